// File: rtl/arbitro_memoria_jogadas_pkg.sv
// Shared definitions for the sequence-memory arbiter: state codes, debug widths
// and the helper that extracts one requester's slice from a packed bus.
package arbitro_memoria_jogadas_pkg;

    localparam int unsigned ESTADO_W    = 3;
    localparam int unsigned DONO_W      = 2;
    localparam int unsigned VETOR_MAX_W = 64;
    localparam int unsigned FATIA_MAX_W = 16;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO = 3'd0,
        POSSE  = 3'd1,
        LIBERA = 3'd2
    } estado_t;

    // Returns field 'indice' of width 'largura' from a packed vector (zero-extended).
    function automatic logic [FATIA_MAX_W-1:0] fatia(
        input logic [VETOR_MAX_W-1:0] vetor,
        input int unsigned            largura,
        input int unsigned            indice
    );
        logic [VETOR_MAX_W-1:0] desl;
        logic [VETOR_MAX_W-1:0] mascara;
        desl    = vetor >> (indice * largura);
        mascara = (VETOR_MAX_W'(1) << largura) - VETOR_MAX_W'(1);
        return FATIA_MAX_W'(desl & mascara);
    endfunction

endpackage

// File: rtl/arbitro_memoria_jogadas_seletor_round_robin.sv
// Combinational winner selection among the active requests.
// Default: round robin, scanning from ultimo+1 modulo NREQ.
// With ARBITRO_PRIORIDADE_FIXA_EN defined: fixed priority, lowest index wins.
// Ports:
//   req        in   per-requester request level
//   ultimo     in   index of the last owner
//   vencedor_c out  index of the selected requester
//   valido_c   out  at least one request is active
module arbitro_memoria_jogadas_seletor_round_robin
    import arbitro_memoria_jogadas_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]   req,
    input  logic [DONO_W-1:0] ultimo,
    output logic [DONO_W-1:0] vencedor_c,
    output logic              valido_c
);

`ifdef ARBITRO_PRIORIDADE_FIXA_EN
    logic [DONO_W-1:0] unused_ultimo;
    assign unused_ultimo = ultimo;

    // Descending scan so the lowest active index is the last assignment.
    always_comb begin
        vencedor_c = '0;
        valido_c   = 1'b0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                vencedor_c = DONO_W'(i);
                valido_c   = 1'b1;
            end
        end
    end
`else
    int unsigned dist_c;
    int unsigned melhor_c;

    // Distance from ultimo+1 (mod NREQ); the smallest distance wins,
    // so the previous owner has the lowest priority.
    always_comb begin
        vencedor_c = '0;
        valido_c   = 1'b0;
        dist_c     = 0;
        melhor_c   = NREQ;
        for (int unsigned i = 0; i < NREQ; i++) begin
            dist_c = (i + 2 * NREQ - 32'(ultimo) - 1) % NREQ;
            if (req[i] && (dist_c < melhor_c)) begin
                melhor_c   = dist_c;
                vencedor_c = DONO_W'(i);
                valido_c   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/arbitro_memoria_jogadas.sv
// Arbiter for the shared sequence memory. Grants exclusive ownership to one
// requester at a time, muxes the owner's address/data/write-enable onto the
// memory port and forces release after MAX_POSSE consecutive owned cycles.
// Optional macro ARBITRO_PRIORIDADE_FIXA_EN selects fixed priority instead of
// round robin.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   req, rel, we_in     per-requester request level, release pulse, write enable
//   addr_in, data_in    packed per-requester address / write data
//   gnt                 one-hot grant
//   mem_we/addr/data    memory port
//   ocupado             high in POSSE and LIBERA
//   db_dono, db_estado  current/last owner, state code
//   db_timeout          sticky forced-release flag, cleared at the next grant
module arbitro_memoria_jogadas
    import arbitro_memoria_jogadas_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned MAX_POSSE = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          rel,
    input  logic [NREQ-1:0]          we_in,
    input  logic [NREQ*ADDR_W-1:0]   addr_in,
    input  logic [NREQ*DATA_W-1:0]   data_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     ocupado,
    output logic [DONO_W-1:0]        db_dono,
    output logic [ESTADO_W-1:0]      db_estado,
    output logic                     db_timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_POSSE);

    estado_t             estado_q, estado_d;
    logic [DONO_W-1:0]   dono_q, dono_d;
    logic [DONO_W-1:0]   ultimo_q, ultimo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [DONO_W-1:0]   vencedor_c;
    logic                valido_c;
    logic                req_dono_c;
    logic                rel_dono_c;
    logic                we_dono_c;
    logic [ADDR_W-1:0]   addr_dono_c;
    logic [DATA_W-1:0]   data_dono_c;

    arbitro_memoria_jogadas_seletor_round_robin #(
        .NREQ (NREQ)
    ) u_seletor (
        .req        (req),
        .ultimo     (ultimo_q),
        .vencedor_c (vencedor_c),
        .valido_c   (valido_c)
    );

    // Current owner's view of the request buses.
    always_comb begin
        req_dono_c  = 1'(fatia(VETOR_MAX_W'(req),   1, 32'(dono_q)));
        rel_dono_c  = 1'(fatia(VETOR_MAX_W'(rel),   1, 32'(dono_q)));
        we_dono_c   = 1'(fatia(VETOR_MAX_W'(we_in), 1, 32'(dono_q)));
        addr_dono_c = ADDR_W'(fatia(VETOR_MAX_W'(addr_in), ADDR_W, 32'(dono_q)));
        data_dono_c = DATA_W'(fatia(VETOR_MAX_W'(data_in), DATA_W, 32'(dono_q)));
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Owner, round-robin pointer, hold counter and held memory-port values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dono_q    <= '0;
            ultimo_q  <= DONO_W'(NREQ - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            dono_q    <= dono_d;
            ultimo_q  <= ultimo_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        estado_d  = estado_q;
        dono_d    = dono_q;
        ultimo_d  = ultimo_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        addr_d    = addr_q;
        data_d    = data_q;
        case (estado_q)
            OCIOSO: begin
                if (valido_c) begin
                    dono_d    = vencedor_c;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    estado_d  = POSSE;
                end
            end
            POSSE: begin
                addr_d = addr_dono_c;
                data_d = data_dono_c;
                cnt_d  = cnt_q + CNT_W'(1);
                // A voluntary release outranks the watchdog in the same cycle.
                if (rel_dono_c || !req_dono_c) begin
                    estado_d = LIBERA;
                end else if (cnt_q == CNT_W'(MAX_POSSE - 1)) begin
                    estado_d  = LIBERA;
                    timeout_d = 1'b1;
                end
            end
            LIBERA: begin
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
                ultimo_d = dono_q;
`endif
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Moore outputs; address/data pass through live only while owned.
    always_comb begin
        gnt      = '0;
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_data = data_q;
        ocupado  = 1'b0;
        case (estado_q)
            POSSE: begin
                gnt      = NREQ'(1) << dono_q;
                mem_we   = we_dono_c;
                mem_addr = addr_dono_c;
                mem_data = data_dono_c;
                ocupado  = 1'b1;
            end
            LIBERA: begin
                ocupado = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_dono    = dono_q;
    assign db_estado  = estado_q;
    assign db_timeout = timeout_q;

endmodule

// File: tb/tb_arbitro_memoria_jogadas.sv
// Directed bench for arbitro_memoria_jogadas (NREQ=2, MAX_POSSE=8).
module tb_arbitro_memoria_jogadas;

    localparam int unsigned NREQ      = 2;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned MAX_POSSE = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        rel;
    logic [NREQ-1:0]        we_in;
    logic [NREQ*ADDR_W-1:0] addr_in;
    logic [NREQ*DATA_W-1:0] data_in;
    logic [NREQ-1:0]        gnt;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data;
    logic                   ocupado;
    logic [1:0]             db_dono;
    logic [2:0]             db_estado;
    logic                   db_timeout;

    int checks   = 0;
    int failures = 0;

    arbitro_memoria_jogadas #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_POSSE (MAX_POSSE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .rel        (rel),
        .we_in      (we_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .gnt        (gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .ocupado    (ocupado),
        .db_dono    (db_dono),
        .db_estado  (db_estado),
        .db_timeout (db_timeout)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic passo();
        @(negedge clock);
    endtask

    // Steps negedges until a grant appears; n counts the grant-free cycles seen.
    task automatic espera_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 20) begin
            n++;
            passo();
        end
        verifica("espera_gnt_limite", 32'(n < 20), 32'h1);
    endtask

    task automatic aplica_reset();
        reset   = 1'b0;
        req     = '0;
        rel     = '0;
        we_in   = '0;
        addr_in = '0;
        data_in = '0;
        passo();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulacao nao terminou");
        $fatal(1);
    end

    initial begin
        int n;
        reset   = 1'b0;
        req     = '0;
        rel     = '0;
        we_in   = '0;
        addr_in = '0;
        data_in = '0;
        passo();
        passo();

        // Reset state
        verifica("rst_gnt",     32'(gnt),        32'h0);
        verifica("rst_mem_we",  32'(mem_we),     32'h0);
        verifica("rst_addr",    32'(mem_addr),   32'h0);
        verifica("rst_data",    32'(mem_data),   32'h0);
        verifica("rst_ocupado", 32'(ocupado),    32'h0);
        verifica("rst_timeout", 32'(db_timeout), 32'h0);
        verifica("rst_estado",  32'(db_estado),  32'h0);
        verifica("rst_dono",    32'(db_dono),    32'h0);
        reset = 1'b1;
        passo();

        // Single grant, write, release
        req = 2'b01; we_in = 2'b01; addr_in = 8'h03; data_in = 8'h09;
        verifica("t1_gnt_antes", 32'(gnt), 32'h0);
        passo();
        verifica("t1_gnt",     32'(gnt),       32'h1);
        verifica("t1_mem_we",  32'(mem_we),    32'h1);
        verifica("t1_addr",    32'(mem_addr),  32'h3);
        verifica("t1_data",    32'(mem_data),  32'h9);
        verifica("t1_estado",  32'(db_estado), 32'h1);
        verifica("t1_ocupado", 32'(ocupado),   32'h1);
        rel = 2'b01;
        passo();
        verifica("t1_lib_gnt",     32'(gnt),       32'h0);
        verifica("t1_lib_estado",  32'(db_estado), 32'h2);
        verifica("t1_lib_we",      32'(mem_we),    32'h0);
        verifica("t1_lib_ocupado", 32'(ocupado),   32'h1);
        rel = '0; req = '0; we_in = '0; addr_in = 8'hFF; data_in = 8'hFF;
        passo();
        verifica("t1_oci_estado",  32'(db_estado), 32'h0);
        verifica("t1_oci_ocupado", 32'(ocupado),   32'h0);
        verifica("t1_oci_addr",    32'(mem_addr),  32'h3);
        verifica("t1_oci_data",    32'(mem_data),  32'h9);

        // Round robin with both requesting continuously
        aplica_reset();
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            espera_gnt(n);
            if (g > 0) verifica($sformatf("t2_intervalo%0d", g), 32'(n), 32'd2);
            verifica($sformatf("t2_ordem%0d", g), 32'(gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
            verifica($sformatf("t2_dono%0d", g), 32'(db_dono), 32'(g % 2));
            passo();
            passo();
            rel = gnt;
            passo();
            rel = '0;
        end
        req = '0;
        passo();

        // Non-owner signals must not reach the memory port
        req = 2'b10; we_in = 2'b01; addr_in = 8'hA5; data_in = 8'hC6;
        espera_gnt(n);
        verifica("t3_gnt",    32'(gnt),      32'h2);
        verifica("t3_dono",   32'(db_dono),  32'h1);
        verifica("t3_we0",    32'(mem_we),   32'h0);
        verifica("t3_addr",   32'(mem_addr), 32'hA);
        verifica("t3_data",   32'(mem_data), 32'hC);
        we_in = 2'b11;
        #1;
        verifica("t3_we1", 32'(mem_we), 32'h1);
        we_in = 2'b01; addr_in = 8'hB5;
        #1;
        verifica("t3_we_volta", 32'(mem_we),   32'h0);
        verifica("t3_addr_b",   32'(mem_addr), 32'hB);
        req = '0;
        passo();
        verifica("t3_lib_estado", 32'(db_estado), 32'h2);
        verifica("t3_lib_addr",   32'(mem_addr),  32'hB);
        passo();

        // Watchdog: owner never releases
        req = 2'b01; we_in = '0;
        espera_gnt(n);
        n = 0;
        while (gnt == 2'b01 && n < 20) begin
            n++;
            passo();
        end
        verifica("t4_ciclos_posse", 32'(n),          32'd8);
        verifica("t4_timeout",      32'(db_timeout), 32'h1);
        verifica("t4_estado",       32'(db_estado),  32'h2);
        passo();
        verifica("t4_timeout_oci", 32'(db_timeout), 32'h1);
        verifica("t4_gnt_oci",     32'(gnt),        32'h0);
        passo();
        verifica("t4_regrant",       32'(gnt),        32'h1);
        verifica("t4_timeout_limpo", 32'(db_timeout), 32'h0);

        // Release on the same cycle the counter reaches its limit
        repeat (7) passo();
        verifica("t5_ainda_posse", 32'(gnt), 32'h1);
        rel = 2'b01;
        passo();
        verifica("t5_estado",  32'(db_estado),  32'h2);
        verifica("t5_timeout", 32'(db_timeout), 32'h0);
        rel = '0; req = '0;
        passo();

        // Asynchronous reset during a write
        req = 2'b01; we_in = 2'b01; addr_in = 8'h07; data_in = 8'h02;
        espera_gnt(n);
        verifica("t6_we_antes", 32'(mem_we), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        verifica("t6_rst_gnt",     32'(gnt),       32'h0);
        verifica("t6_rst_we",      32'(mem_we),    32'h0);
        verifica("t6_rst_estado",  32'(db_estado), 32'h0);
        verifica("t6_rst_addr",    32'(mem_addr),  32'h0);
        verifica("t6_rst_ocupado", 32'(ocupado),   32'h0);
        passo();
        reset = 1'b1; req = 2'b10; we_in = '0;
        espera_gnt(n);
        verifica("t6_gnt1",  32'(gnt),     32'h2);
        verifica("t6_dono1", 32'(db_dono), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
